// File: rtl/if2_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : if2_fetch_queue
// Description : IF2 in-order fetch queue. Slots are allocated per IF1 request,
//               filled by icache responses in order, and delivered to ID.
// Revision    : 1.0
// ============================================================================
module if2_fetch_queue #(
    parameter int DEPTH = 4,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if1_req,
    input  logic [31:0] if1_pc,
    input  logic        if1_adef,
    input  logic        icache_rvalid,
    input  logic [31:0] icache_rdata,
    input  logic        flush,
    output logic        pc_wen,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_pc,
    output logic [31:0] id_inst,
    output logic        id_adef
);

    localparam int OCC_W  = PTR_W + 1;
    localparam int DROP_W = PTR_W + 2;

    logic [31:0]       r_pc   [DEPTH];
    logic [31:0]       r_inst [DEPTH];
    logic [DEPTH-1:0]  r_adef;
    logic [DEPTH-1:0]  r_filled;
    logic [PTR_W-1:0]  r_head;
    logic [PTR_W-1:0]  r_tail;
    logic [PTR_W-1:0]  r_fill;
    logic [OCC_W-1:0]  r_occ;
    logic [DROP_W-1:0] r_drop;

    logic              w_alloc;
    logic              w_deq;
    logic              w_resp_fill;
    logic              w_resp_drop;
    logic [DEPTH-1:0]  w_filled_next;
    logic [OCC_W-1:0]  w_filled_cnt;
    logic [OCC_W-1:0]  w_unanswered;
    logic [DROP_W-1:0] w_drop_flush;

    assign w_alloc     = if1_req & ~flush;
    assign w_deq       = id_valid & id_ready;
    assign w_resp_drop = icache_rvalid & (r_drop != '0);
    assign w_resp_fill = icache_rvalid & (r_drop == '0);

    assign id_valid = (r_occ != '0) & r_filled[r_head];
    assign id_pc    = r_pc[r_head];
    assign id_inst  = r_inst[r_head];
    assign id_adef  = r_adef[r_head];
    // One slot of margin absorbs IF1's one-cycle lag from pc_wen to if1_req.
    assign pc_wen   = flush | (r_occ <= OCC_W'(DEPTH - 2));

    // Filled bits are cleared on dequeue so they only ever mark live slots.
    always_comb begin
        w_filled_next = r_filled;
        if (w_deq) begin
            w_filled_next[r_head] = 1'b0;
        end
        if (w_resp_fill) begin
            w_filled_next[r_fill] = 1'b1;
        end
        if (w_alloc) begin
            w_filled_next[r_tail] = 1'b0;
        end
    end

    always_comb begin
        w_filled_cnt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_filled_cnt = w_filled_cnt + OCC_W'(r_filled[i]);
        end
    end

    // Every response still owed after the flush must be discarded; a response
    // arriving this cycle (dropped or filling) settles one of them already.
    assign w_unanswered = r_occ - w_filled_cnt;
    assign w_drop_flush = r_drop + DROP_W'(w_unanswered) + DROP_W'(if1_req)
                          - DROP_W'(icache_rvalid);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_pc[i]   <= '0;
                r_inst[i] <= '0;
            end
            r_adef   <= '0;
            r_filled <= '0;
            r_head   <= '0;
            r_tail   <= '0;
            r_fill   <= '0;
            r_occ    <= '0;
            r_drop   <= '0;
        end else begin
            if (w_resp_fill) begin
                r_inst[r_fill] <= r_adef[r_fill] ? 32'h0 : icache_rdata;
            end
            if (w_alloc) begin
                r_pc[r_tail]   <= if1_pc;
                r_adef[r_tail] <= if1_adef;
            end
            if (flush) begin
                r_filled <= '0;
                r_head   <= '0;
                r_tail   <= '0;
                r_fill   <= '0;
                r_occ    <= '0;
                r_drop   <= w_drop_flush;
            end else begin
                r_filled <= w_filled_next;
                r_head   <= r_head + PTR_W'(w_deq);
                r_tail   <= r_tail + PTR_W'(w_alloc);
                r_fill   <= r_fill + PTR_W'(w_resp_fill);
                r_occ    <= r_occ + OCC_W'(w_alloc) - OCC_W'(w_deq);
                if (w_resp_drop) begin
                    r_drop <= r_drop - DROP_W'(1);
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_if2_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_if2_fetch_queue
// Description : Directed-plus-random bench for if2_fetch_queue with a
//               queue-based reference model and an in-order icache model.
// Revision    : 1.0
// ============================================================================
module tb_if2_fetch_queue;

    localparam int DEPTH = 4;
    localparam int PTR_W = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if1_req;
    logic [31:0] if1_pc;
    logic        if1_adef;
    logic        icache_rvalid;
    logic [31:0] icache_rdata;
    logic        flush;
    logic        pc_wen;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
    logic        id_adef;

    always #5 clk = ~clk;

    if2_fetch_queue #(.DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .if1_req       (if1_req),
        .if1_pc        (if1_pc),
        .if1_adef      (if1_adef),
        .icache_rvalid (icache_rvalid),
        .icache_rdata  (icache_rdata),
        .flush         (flush),
        .pc_wen        (pc_wen),
        .id_valid      (id_valid),
        .id_ready      (id_ready),
        .id_pc         (id_pc),
        .id_inst       (id_inst),
        .id_adef       (id_adef)
    );

    typedef struct {
        logic [31:0] pc;
        logic        adef;
        logic        filled;
        logic [31:0] inst;
    } slot_t;

    typedef struct {
        logic [31:0] data;
        int          due;
    } rsp_t;

    slot_t       mq[$];
    rsp_t        ic_q[$];
    int          m_drop, n_deq, n_alloc, n_fill, cyc;
    int          n_cmp, n_bad;
    bit          allow_req, force_flush, force_adef, exp_valid, exp_wen;
    int          req_rate, ready_rate, lat_min, lat_max, flush_pm, adef_pct;
    logic [31:0] next_pc, req_data;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, expv, cyc);
        end
    endtask

    task automatic pick_inputs();
        if (!rst_n) begin
            if1_req       = 1'b0;
            if1_adef      = 1'b0;
            flush         = 1'b0;
            icache_rvalid = 1'b0;
        end else begin
            if1_req  = allow_req && (int'($urandom_range(0, 99)) < req_rate);
            flush    = force_flush || (int'($urandom_range(0, 999)) < flush_pm);
            force_flush = 1'b0;
            if1_adef = 1'b0;
            if1_pc   = next_pc;
            if (if1_req) begin
                if1_adef = force_adef || (int'($urandom_range(0, 99)) < adef_pct);
                force_adef = 1'b0;
                if (if1_adef) if1_pc = next_pc + 32'd2;
            end
            req_data = if1_adef ? 32'hdeadbeef : $urandom;
            icache_rvalid = (ic_q.size() != 0) && (ic_q[0].due <= cyc);
            icache_rdata  = icache_rvalid ? ic_q[0].data : $urandom;
        end
        id_ready = int'($urandom_range(0, 99)) < ready_rate;
    endtask

    task automatic check_outputs();
        exp_valid = (mq.size() != 0) && mq[0].filled;
        exp_wen   = flush || (mq.size() <= DEPTH - 2);
        chk("id_valid", 32'(id_valid), 32'(exp_valid));
        chk("pc_wen", 32'(pc_wen), 32'(exp_wen));
        if (exp_valid) begin
            chk("id_pc", id_pc, mq[0].pc);
            chk("id_inst", id_inst, mq[0].inst);
            chk("id_adef", 32'(id_adef), 32'(mq[0].adef));
        end
        chk("occ", 32'(dut.r_occ), 32'(mq.size()));
        chk("drop", 32'(dut.r_drop), 32'(m_drop));
        chk("head", 32'(dut.r_head), 32'(n_deq % DEPTH));
        chk("tail", 32'(dut.r_tail), 32'(n_alloc % DEPTH));
        chk("fill", 32'(dut.r_fill), 32'(n_fill % DEPTH));
    endtask

    task automatic clear_model();
        mq.delete();
        m_drop  = 0;
        n_deq   = 0;
        n_alloc = 0;
        n_fill  = 0;
    endtask

    task automatic update_model();
        rsp_t  r;
        slot_t s;
        int    unans;
        bit    found;
        if (!rst_n) begin
            clear_model();
            ic_q.delete();
            allow_req = 1'b1;
            return;
        end
        if (icache_rvalid) begin
            r = ic_q.pop_front();
            if (m_drop > 0) begin
                m_drop--;
            end else begin
                found = 1'b0;
                for (int i = 0; i < mq.size(); i++) begin
                    if (!found && !mq[i].filled) begin
                        s = mq[i];
                        s.filled = 1'b1;
                        s.inst = s.adef ? 32'h0 : icache_rdata;
                        mq[i] = s;
                        found = 1'b1;
                    end
                end
                chk("resp_has_slot", 32'(found), 32'd1);
                n_fill++;
            end
        end
        if (if1_req) begin
            r.data = req_data;
            r.due  = cyc + int'($urandom_range(lat_min, lat_max));
            ic_q.push_back(r);
            next_pc = next_pc + 32'd4;
        end
        if (flush) begin
            unans = int'(if1_req);
            foreach (mq[i]) if (!mq[i].filled) unans++;
            m_drop  = m_drop + unans;
            mq.delete();
            n_deq   = 0;
            n_alloc = 0;
            n_fill  = 0;
        end else begin
            if (exp_valid && id_ready) begin
                void'(mq.pop_front());
                n_deq++;
            end
            if (if1_req) begin
                chk("alloc_room", 32'(mq.size() < DEPTH), 32'd1);
                s.pc = if1_pc;
                s.adef = if1_adef;
                s.filled = 1'b0;
                s.inst = 32'h0;
                mq.push_back(s);
                n_alloc++;
            end
        end
        allow_req = exp_wen;
    endtask

    task automatic cycle();
        pick_inputs();
        @(negedge clk);
        if (rst_n) check_outputs();
        update_model();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        run(n);
        rst_n = 1'b1;
        chk("rst_id_valid", 32'(id_valid), 32'd0);
        chk("rst_id_pc", id_pc, 32'd0);
        chk("rst_id_inst", id_inst, 32'd0);
        chk("rst_id_adef", 32'(id_adef), 32'd0);
        chk("rst_pc_wen", 32'(pc_wen), 32'd1);
    endtask

    task automatic set_mode(input int rq, input int rd, input int lmin, input int lmax);
        req_rate   = rq;
        ready_rate = rd;
        lat_min    = lmin;
        lat_max    = lmax;
    endtask

    initial begin
        n_cmp = 0; n_bad = 0; cyc = 0;
        flush_pm = 0; adef_pct = 0;
        force_flush = 1'b0; force_adef = 1'b0; allow_req = 1'b1;
        if1_pc = 32'h0; icache_rdata = 32'h0; req_data = 32'h0;
        next_pc = 32'h1c000000;
        set_mode(0, 100, 1, 1);
        clear_model();
        do_reset(2);

        // Streaming at icache latency 1
        next_pc = 32'h1c000000;
        set_mode(100, 100, 1, 1);
        run(12);

        // Backpressure: ID stalls for 8 cycles
        ready_rate = 0;
        run(8);
        chk("bp_peak_occ", 32'(dut.r_occ), 32'd4);
        ready_rate = 100;
        run(10);

        // Flush with three misses in flight plus one issued in the flush cycle
        set_mode(0, 100, 1, 1);
        run(8);
        set_mode(100, 100, 4, 4);
        run(3);
        chk("flush_pre_occ", 32'(dut.r_occ), 32'd3);
        force_flush = 1'b1;
        run(1);
        chk("flush_post_occ", 32'(dut.r_occ), 32'd0);
        chk("flush_post_drop", 32'(dut.r_drop), 32'd4);
        next_pc = 32'h1c000100;
        set_mode(100, 100, 1, 1);
        for (int k = 0; k < 20 && !id_valid; k++) cycle();
        chk("flush_first_valid", 32'(id_valid), 32'd1);
        chk("flush_first_pc", id_pc, 32'h1c000100);
        run(6);

        // Misaligned PC between aligned neighbours
        set_mode(0, 100, 1, 1);
        run(8);
        next_pc = 32'h1bfffff8;
        set_mode(100, 100, 2, 2);
        run(2);
        force_adef = 1'b1;
        run(1);
        for (int k = 0; k < 20 && !(id_valid && id_adef); k++) cycle();
        chk("adef_flag", 32'(id_adef), 32'd1);
        chk("adef_inst", id_inst, 32'h0);
        chk("adef_pc", id_pc, 32'h1c000002);
        run(8);

        // Allocate, response and dequeue together at occ 2
        set_mode(0, 100, 1, 1);
        run(8);
        set_mode(100, 0, 1, 1);
        run(2);
        chk("simul_pre_occ", 32'(dut.r_occ), 32'd2);
        ready_rate = 100;
        run(1);
        chk("simul_post_occ", 32'(dut.r_occ), 32'd2);
        run(6);

        // Reset with occ 3 and two responses pending discard
        set_mode(0, 100, 1, 1);
        run(8);
        set_mode(100, 100, 8, 8);
        run(2);
        req_rate = 0;
        force_flush = 1'b1;
        run(1);
        req_rate = 100;
        run(3);
        chk("rst_mid_occ", 32'(dut.r_occ), 32'd3);
        chk("rst_mid_drop", 32'(dut.r_drop), 32'd2);
        do_reset(1);
        next_pc = 32'h1c000000;
        set_mode(100, 100, 1, 1);
        run(12);

        // Randomized mix
        set_mode(70, 70, 1, 5);
        flush_pm = 30;
        adef_pct = 5;
        run(400);
        flush_pm = 0;
        adef_pct = 0;
        set_mode(0, 100, 1, 5);
        run(30);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
